tp_spi_responder: RTL and testbench



---
 rtl/tp_spi_pkg.sv | 47 ++++
 rtl/tp_spi_edge_sync.sv | 35 +++
 rtl/tp_spi_responder.sv | 194 +++++++++++++++++++
 tb/tb_tp_spi_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tp_spi_pkg.sv
// tp_spi_pkg: shared types and constants for the touch-panel SPI responder.
//   - tp_resp_state_t: responder FSM states (encodings fixed for debug visibility)
//   - command byte field positions, default channel codes, noise LFSR seed
//   - tp_select_word: maps a channel address and touch state to a 12-bit word
package tp_spi_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    CMD        = 3'd2,
    BUSY_ST    = 3'd3,
    SHIFT      = 3'd4
  } tp_resp_state_t;

  // Control byte layout: S A2 A1 A0 MODE SER/DFR PD1 PD0
  localparam int CMD_START    = 7;
  localparam int CMD_ADDR_MSB = 6;
  localparam int CMD_ADDR_LSB = 4;
  localparam int CMD_MODE     = 3;
  localparam int CMD_SER      = 2;
  localparam int CMD_PD_MSB   = 1;
  localparam int CMD_PD_LSB   = 0;

  localparam logic [2:0]  X_CHAN_DEF = 3'b001;
  localparam logic [2:0]  Y_CHAN_DEF = 3'b101;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam int          DATA_W     = 12;

  // No touch reads as zero on every channel; unknown channels read as zero.
  function automatic logic [DATA_W-1:0] tp_select_word(
    input logic [2:0]        addr,
    input logic              touch,
    input logic [DATA_W-1:0] x_val,
    input logic [DATA_W-1:0] y_val,
    input logic [2:0]        x_chan,
    input logic [2:0]        y_chan
  );
    logic [DATA_W-1:0] w;
    w = '0;
    if (touch) begin
      if (addr == x_chan)      w = x_val;
      else if (addr == y_chan) w = y_val;
    end
    return w;
  endfunction

endpackage

// File: rtl/tp_spi_edge_sync.sv
// tp_spi_edge_sync: multi-flop synchronizer with single-cycle edge pulses.
//   Clock, Resetn : system clock, async active-low reset
//   d             : asynchronous input
//   q             : synchronized level (last synchronizer stage)
//   rise, fall    : one-Clock pulses when q differs from its registered copy
module tp_spi_edge_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/tp_spi_responder.sv
// tp_spi_responder: ADS7843-style touch-panel ADC emulator (SPI responder).
//   Clock, Resetn        : system clock, async active-low reset
//   TP_SCLK_I/MOSI_I/SS_N_I : SPI from the initiator (SCLK idles low)
//   TP_MISO_O, TP_BUSY_O : conversion data and busy flag, updated on SCLK fall
//   TP_PENIRQ_N_O        : active-low pen interrupt
//   Touch_I, X/Y_Coord_I : stimulus for the emulated panel
//   Last_Cmd_O           : most recent complete control byte
//   Conv_Count_O         : completed (non-aborted) conversions, wrapping
//   State_O              : current FSM state (tp_resp_state_t encoding)
// Optional build macro TP_RESP_JITTER_EN adds LFSR noise on data bits [1:0].
//
// Link protocol: the initiator drives MOSI while SCLK is low; the responder
// samples it on the synchronized SCLK rise. MISO/BUSY are driven on the
// synchronized SCLK fall, so they are stable at the following rise. SS_N high
// aborts any transaction. There is no other handshake.
module tp_spi_responder
  import tp_spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [2:0] X_CHAN      = X_CHAN_DEF,
  parameter logic [2:0] Y_CHAN      = Y_CHAN_DEF
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        TP_SCLK_I,
  input  logic        TP_MOSI_I,
  input  logic        TP_SS_N_I,
  output logic        TP_MISO_O,
  output logic        TP_BUSY_O,
  output logic        TP_PENIRQ_N_O,
  input  logic        Touch_I,
  input  logic [11:0] X_Coord_I,
  input  logic [11:0] Y_Coord_I,
  output logic [7:0]  Last_Cmd_O,
  output logic [15:0] Conv_Count_O,
  output logic [2:0]  State_O
);

  logic sclk_q, sclk_rise, sclk_fall;
  logic mosi_q, mosi_rise, mosi_fall;
  logic ssn_q, ssn_rise, ssn_fall;

  tp_spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .Clock(Clock), .Resetn(Resetn), .d(TP_SCLK_I),
    .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  tp_spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .Clock(Clock), .Resetn(Resetn), .d(TP_MOSI_I),
    .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));
  tp_spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ssn (
    .Clock(Clock), .Resetn(Resetn), .d(TP_SS_N_I),
    .q(ssn_q), .rise(ssn_rise), .fall(ssn_fall));

  // Only the SCLK edges and the MOSI/SS_N levels drive the FSM.
  logic sync_unused;
  assign sync_unused = ^{sclk_q, mosi_rise, mosi_fall, ssn_rise, ssn_fall};

  tp_resp_state_t state;
  logic [7:0]  cmd_sr;
  logic [2:0]  bit_cnt;
  logic [11:0] data_sr;
  logic [3:0]  bit_num;
  logic        mode8;
  logic        miso_r, busy_r, penirq_n_r;
  logic [7:0]  last_cmd_r;
  logic [15:0] conv_count_r;

  logic [7:0]  cmd_next;
  logic        latch_en;
  logic [11:0] base_word;
  logic [11:0] latched_word;
  logic [3:0]  last_bit;

  assign cmd_next  = {cmd_sr[6:0], mosi_q};
  assign latch_en  = !ssn_q && (state == CMD) && sclk_rise && (bit_cnt == 3'd7);
  assign base_word = tp_select_word(cmd_next[CMD_ADDR_MSB:CMD_ADDR_LSB], Touch_I,
                                    X_Coord_I, Y_Coord_I, X_CHAN, Y_CHAN);
  assign last_bit  = mode8 ? 4'd8 : 4'd12;

`ifdef TP_RESP_JITTER_EN
  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, stepped once per latched command.
  logic [15:0] lfsr;
  logic        is_xy;
  assign is_xy = (cmd_next[CMD_ADDR_MSB:CMD_ADDR_LSB] == X_CHAN) ||
                 (cmd_next[CMD_ADDR_MSB:CMD_ADDR_LSB] == Y_CHAN);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) lfsr <= LFSR_SEED;
    else if (latch_en) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign latched_word = base_word ^ {10'b0, (Touch_I && is_xy) ? lfsr[1:0] : 2'b00};
`else
  assign latched_word = base_word;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state        <= IDLE;
      cmd_sr       <= '0;
      bit_cnt      <= '0;
      data_sr      <= '0;
      bit_num      <= '0;
      mode8        <= 1'b0;
      miso_r       <= 1'b0;
      busy_r       <= 1'b0;
      last_cmd_r   <= '0;
      conv_count_r <= '0;
    end else if (ssn_q && state != IDLE) begin
      // Abort: an unfinished conversion is not counted.
      state  <= IDLE;
      miso_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          miso_r <= 1'b0;
          busy_r <= 1'b0;
          if (!ssn_q) state <= WAIT_START;
        end
        WAIT_START: begin
          // Leading zeros are discarded; the first sampled 1 is the start bit.
          if (sclk_rise && mosi_q) begin
            cmd_sr  <= 8'h01;
            bit_cnt <= 3'd1;
            state   <= CMD;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            cmd_sr  <= cmd_next;
            bit_cnt <= 3'(bit_cnt + 3'd1);
            if (bit_cnt == 3'd7) begin
              last_cmd_r <= cmd_next;
              data_sr    <= latched_word;
              mode8      <= cmd_next[CMD_MODE];
              state      <= BUSY_ST;
            end
          end
        end
        BUSY_ST: begin
          // First fall raises BUSY, second fall drops it and presents the MSB.
          if (sclk_fall) begin
            if (!busy_r) begin
              busy_r <= 1'b1;
            end else begin
              busy_r  <= 1'b0;
              miso_r  <= data_sr[11];
              data_sr <= {data_sr[10:0], 1'b0};
              bit_num <= 4'd1;
              state   <= SHIFT;
            end
          end
        end
        SHIFT: begin
          // Rises are ignored here, so overlapped start bits are dropped.
          if (sclk_fall) begin
            if (bit_num == last_bit) begin
              miso_r       <= 1'b0;
              conv_count_r <= conv_count_r + 16'd1;
              state        <= WAIT_START;
            end else begin
              miso_r  <= data_sr[11];
              data_sr <= {data_sr[10:0], 1'b0};
              bit_num <= 4'(bit_num + 4'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pen interrupt follows the panel unless a conversion is in flight or the
  // last command asked for power-down interrupt disable (PD0=1).
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      penirq_n_r <= 1'b1;
    end else if (state == CMD || state == BUSY_ST || state == SHIFT) begin
      penirq_n_r <= 1'b1;
    end else if (state == IDLE || !last_cmd_r[CMD_PD_LSB]) begin
      penirq_n_r <= ~Touch_I;
    end else begin
      penirq_n_r <= 1'b1;
    end
  end

  assign TP_MISO_O     = miso_r;
  assign TP_BUSY_O     = busy_r;
  assign TP_PENIRQ_N_O = penirq_n_r;
  assign Last_Cmd_O    = last_cmd_r;
  assign Conv_Count_O  = conv_count_r;
  assign State_O       = state;

endmodule

// File: tb/tb_tp_spi_responder.sv
// tb_tp_spi_responder: directed bench for tp_spi_responder. SCLK runs at
// Clock/16; the bench acts as the SPI initiator and reads MISO just before
// each SCLK rise.
module tb_tp_spi_responder;
  import tp_spi_pkg::*;

  localparam int SYNC = 2;
  localparam int HALF = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sclk, mosi, ss_n, touch;
  logic [11:0] x_val, y_val;
  logic        miso, busy, penirq_n;
  logic [7:0]  last_cmd;
  logic [15:0] conv_count;
  logic [2:0]  state_dbg;

  tp_spi_responder #(.SYNC_STAGES(SYNC)) dut (
    .Clock(clk), .Resetn(rst_n),
    .TP_SCLK_I(sclk), .TP_MOSI_I(mosi), .TP_SS_N_I(ss_n),
    .TP_MISO_O(miso), .TP_BUSY_O(busy), .TP_PENIRQ_N_O(penirq_n),
    .Touch_I(touch), .X_Coord_I(x_val), .Y_Coord_I(y_val),
    .Last_Cmd_O(last_cmd), .Conv_Count_O(conv_count), .State_O(state_dbg));

  // scoreboard
  int n_pass = 0;
  int n_total = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_word(input string name, input logic [11:0] act, input logic noisy);
    logic [11:0] exp, mask;
    mask = 12'hFFF;
`ifdef TP_RESP_JITTER_EN
    if (noisy) mask = 12'hFFC;
`endif
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 16'd1, 16'd0);
    end else begin
      exp = exp_q.pop_front();
      check(name, 16'(act & mask), 16'(exp & mask));
    end
  endtask

  // driver tasks
  task automatic sclk_cycle(input logic b, output logic miso_s, output logic busy_s,
                            output logic pen_s);
    mosi = b;
    repeat (HALF) @(negedge clk);
    miso_s = miso;
    busy_s = busy;
    pen_s  = penirq_n;
    sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] cmd, output logic busy_seen);
    logic m, b, p;
    busy_seen = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      sclk_cycle(cmd[i], m, b, p);
      busy_seen |= b;
    end
  endtask

  // One BUSY cycle then nbits data cycles; optionally changes the coordinates
  // partway through the shift.
  task automatic read_resp(input int nbits, input logic chg, input logic [11:0] nx,
                           input logic [11:0] ny, output logic [11:0] word,
                           output logic busy1, output logic busy_after,
                           output logic pen_hi);
    logic m, b, p;
    word = '0;
    busy_after = 1'b0;
    pen_hi = 1'b1;
    sclk_cycle(1'b0, m, busy1, p);
    pen_hi &= p;
    for (int j = 2; j <= nbits + 1; j++) begin
      if (chg && j == 5) begin
        x_val = nx;
        y_val = ny;
      end
      sclk_cycle(1'b0, m, b, p);
      word = {word[10:0], m};
      busy_after |= b;
      pen_hi &= p;
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic ss_release();
    ss_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic ss_assert();
    ss_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic        touch;
    logic [11:0] x;
    logic [11:0] y;
    int          nbits;
    logic [11:0] exp_word;
    logic        noisy;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [11:0] word;
    logic        b1, b_after, pen_hi, b_cmd, m, b, p;
    logic [15:0] exp_count;
    logic [11:0] xs[4];
    logic [11:0] ys[4];

    vecs[0] = '{8'h90, 1'b1, 12'hA5C, 12'h3F7, 12, 12'hA5C, 1'b1};
    vecs[1] = '{8'hD8, 1'b1, 12'hA5C, 12'h3F7,  8, 12'h03F, 1'b0};
    vecs[2] = '{8'h90, 1'b0, 12'hA5C, 12'h3F7, 12, 12'h000, 1'b0};
    vecs[3] = '{8'hA0, 1'b1, 12'hA5C, 12'h3F7, 12, 12'h000, 1'b0};
    vecs[4] = '{8'hD0, 1'b1, 12'h111, 12'h123, 12, 12'h123, 1'b1};
    vecs[5] = '{8'h98, 1'b1, 12'hA5C, 12'h3F7,  8, 12'h0A5, 1'b0};
    vecs[6] = '{8'hD4, 1'b1, 12'h000, 12'hFFF, 12, 12'hFFF, 1'b1};

    sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1; touch = 1'b0;
    x_val = '0; y_val = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_miso", 16'(miso), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_penirq", 16'(penirq_n), 16'd1);
    check("rst_last_cmd", 16'(last_cmd), 16'd0);
    check("rst_count", conv_count, 16'd0);
    check("rst_state", 16'(state_dbg), 16'(IDLE));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // table-driven single conversions
    exp_count = 16'd0;
    foreach (vecs[i]) begin
      touch = vecs[i].touch;
      x_val = vecs[i].x;
      y_val = vecs[i].y;
      ss_assert();
      exp_q.push_back(vecs[i].exp_word);
      send_byte(vecs[i].cmd, b_cmd);
      read_resp(vecs[i].nbits, 1'b0, '0, '0, word, b1, b_after, pen_hi);
      exp_count++;
      check_word($sformatf("v%0d_word", i), word, vecs[i].noisy);
      check($sformatf("v%0d_busy_in_cmd", i), 16'(b_cmd), 16'd0);
      check($sformatf("v%0d_busy_pulse", i), 16'(b1), 16'd1);
      check($sformatf("v%0d_busy_after", i), 16'(b_after), 16'd0);
      check($sformatf("v%0d_miso_end", i), 16'(miso), 16'd0);
      check($sformatf("v%0d_last_cmd", i), 16'(last_cmd), 16'(vecs[i].cmd));
      check($sformatf("v%0d_count", i), conv_count, exp_count);
      ss_release();
    end

    // leading zeros with no touch
    touch = 1'b0;
    x_val = 12'hA5C;
    ss_assert();
    exp_q.push_back(12'h000);
    send_byte(8'h00, b_cmd);
    send_byte(8'h90, b_cmd);
    read_resp(12, 1'b0, '0, '0, word, b1, b_after, pen_hi);
    exp_count++;
    check_word("lz_word", word, 1'b0);
    check("lz_last_cmd", 16'(last_cmd), 16'h0090);
    check("lz_pen_during", 16'(pen_hi), 16'd1);
    check("lz_pen_after", 16'(penirq_n), 16'd1);
    check("lz_count", conv_count, exp_count);
    ss_release();

    // pen interrupt in IDLE, then PD0=1 holds it high until SS_N rises
    check("pen_idle_untouched", 16'(penirq_n), 16'd1);
    touch = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    check("pen_idle_touched", 16'(penirq_n), 16'd0);
    x_val = 12'h5A3;
    ss_assert();
    exp_q.push_back(12'h5A3);
    send_byte(8'h91, b_cmd);
    read_resp(12, 1'b0, '0, '0, word, b1, b_after, pen_hi);
    exp_count++;
    check_word("pd1_word", word, 1'b1);
    check("pd1_pen_during", 16'(pen_hi), 16'd1);
    repeat (20) @(negedge clk);
    check("pd1_pen_hold", 16'(penirq_n), 16'd1);
    ss_n = 1'b1;
    repeat (SYNC + 3) @(negedge clk);
    check("pd1_pen_released", 16'(penirq_n), 16'd0);

    // abort after 5 data bits
    x_val = 12'hFFF;
    ss_assert();
    send_byte(8'h90, b_cmd);
    sclk_cycle(1'b0, m, b, p);
    for (int j = 0; j < 5; j++) sclk_cycle(1'b0, m, b, p);
    repeat (HALF) @(negedge clk);
    check("abort_miso_before", 16'(miso), 16'd1);
    ss_n = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    check("abort_state", 16'(state_dbg), 16'(IDLE));
    check("abort_miso", 16'(miso), 16'd0);
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_count", conv_count, exp_count);
    repeat (4) @(negedge clk);
    x_val = 12'hA5C;
    ss_assert();
    exp_q.push_back(12'hA5C);
    send_byte(8'h90, b_cmd);
    read_resp(12, 1'b0, '0, '0, word, b1, b_after, pen_hi);
    exp_count++;
    check_word("post_abort_word", word, 1'b1);
    check("post_abort_count", conv_count, exp_count);
    ss_release();

    // back-to-back pairs, coordinates changed mid-shift
    xs[0] = 12'hA5C; xs[1] = 12'h123; xs[2] = 12'hF0F; xs[3] = 12'h800;
    ys[0] = 12'h3F7; ys[1] = 12'h456; ys[2] = 12'h0F0; ys[3] = 12'h001;
    ss_assert();
    for (int k = 0; k < 4; k++) begin
      x_val = xs[k];
      y_val = ys[k];
      exp_q.push_back(xs[k]);
      send_byte(8'h90, b_cmd);
      read_resp(12, 1'b1, ~xs[k], ~ys[k], word, b1, b_after, pen_hi);
      check_word($sformatf("b2b%0d_x", k), word, 1'b1);
      x_val = xs[k];
      y_val = ys[k];
      exp_q.push_back(ys[k]);
      send_byte(8'hD0, b_cmd);
      read_resp(12, 1'b1, ~xs[k], ~ys[k], word, b1, b_after, pen_hi);
      check_word($sformatf("b2b%0d_y", k), word, 1'b1);
    end
    exp_count += 16'd8;
    check("b2b_count", conv_count, exp_count);
    check("b2b_last_cmd", 16'(last_cmd), 16'h00D0);
    ss_release();

    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
